// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring unsigned divider, one quotient bit per clock.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] p, a, d, pn;
  logic [WIDTH:0] pp;
  logic [CW-1:0] cnt;
  logic ge, accept, last;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    pp = {p, a[WIDTH-1]};
    ge = pp >= {1'b0, d};
    // when no subtraction happens pp < d, so its top bit is already zero
    pn = ge ? WIDTH'(pp - {1'b0, d}) : pp[WIDTH-1:0];
    accept = start && state != RUN;
    last = cnt == CW'(WIDTH - 1);
    state_n = state;
    if (accept) state_n = divisor == '0 ? DONE : RUN;
    else if (state == DONE) state_n = IDLE;
    else if (state == RUN && last) state_n = DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p <= '0;
      a <= '0;
      d <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        p <= '0;
        a <= dividend;
        d <= divisor;
        cnt <= '0;
        if (divisor == '0) begin
          quotient <= '1;
          remainder <= dividend;
          div_by_zero <= 1'b1;
        end
      end else if (state == RUN) begin
        p <= pn;
        a <= {a[WIDTH-2:0], ge};
        cnt <= cnt + 1'b1;
        if (last) begin
          quotient <= {a[WIDTH-2:0], ge};
          remainder <= pn;
          div_by_zero <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors checked by a queue-based scoreboard and a done monitor.
module tb_seq_divider;
  localparam int W = 32;
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    int           s;
  } exp_t;
  logic clk = 0, rst = 1, start = 0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  exp_t sb[$];
  int cyc = 0, total = 0, bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // the edge that samples done is cyc+1; latency counts edges from the accepting edge
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", W'(div_by_zero), W'(e.dz));
        chk("latency", W'(cyc + 1 - e.s), W'(e.lat));
      end
    end
  end

  task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz, input int s);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.s = s; e.lat = dz ? 1 : W + 1;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout", W'(sb.size()), '0);
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                        input logic [W-1:0] q, input logic [W-1:0] r);
    @(negedge clk);
    start = 1; dividend = dd; divisor = dv;
    push(q, r, dv == '0, cyc + 1);
    @(posedge clk);
    #1 start = 0;
    if (dv == '0) begin
      chk("dz_busy", W'(busy), '0);
      chk("dz_done", W'(done), W'(1));
    end else chk("busy_rise", W'(busy), W'(1));
    drain();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_q", quotient, '0);
    chk("rst_r", remainder, '0);
    chk("rst_dz", W'(div_by_zero), '0);
    rst = 0;
    run_op(1024, 1, 1024, 0);
    run_op(2051, 2, 1025, 1);
    run_op(2051, 3, 683, 2);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
    run_op(5, 7, 0, 5);
    run_op(32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0);
    run_op(0, 9, 0, 0);
    run_op(100, 0, 32'hFFFFFFFF, 100);
    chk("dz_hold", W'(div_by_zero), W'(1));
    // start pulsed mid-run must not disturb the operation
    @(negedge clk);
    start = 1; dividend = 1000; divisor = 10;
    push(100, 0, 0, cyc + 1);
    @(posedge clk);
    #1 start = 0;
    repeat (5) @(posedge clk);
    #1 start = 1; dividend = 7; divisor = 2;
    @(posedge clk);
    #1 start = 0;
    chk("ignored_busy", W'(busy), W'(1));
    drain();
    // reset aborts a run; start presented during reset is ignored
    @(negedge clk);
    start = 1; dividend = 1000; divisor = 7;
    @(posedge clk);
    #1 start = 0;
    repeat (9) @(posedge clk);
    #1 rst = 1; start = 1; dividend = 9; divisor = 4;
    @(posedge clk);
    #1;
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(done), '0);
    chk("abort_q", quotient, '0);
    chk("abort_r", remainder, '0);
    chk("abort_dz", W'(div_by_zero), '0);
    rst = 0;
    push(2, 1, 0, cyc + 1);
    @(posedge clk);
    #1 start = 0;
    chk("post_rst_busy", W'(busy), W'(1));
    drain();
    // start held high: each done edge accepts the next operation
    @(negedge clk);
    start = 1; dividend = 2051; divisor = 3;
    for (int k = 0; k < 3; k++) push(683, 2, 0, cyc + 1 + k * (W + 1));
    repeat (2 * (W + 1) + 1) @(posedge clk);
    #1 start = 0;
    drain();
    chk("sb_empty", W'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
